// File: rtl/pwm_generator.sv
// PWM generator with soft-start ramp.
// A prescaler divides clk into PWM steps. One PWM period is 100 steps.
// The applied duty (active_duty) changes only at period boundaries. Upward changes
// are limited to RAMP_STEP percent per period. Downward changes take effect at once
// at the next boundary.
// Interface semantics: this block has no handshake. enable is a level-sensitive run
// request. pwm_duty is a free-running target that is sampled every clk.
module pwm_generator #(
  parameter int CLK_DIV   = 10,
  parameter int RAMP_STEP = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] pwm_duty,
  output logic       pwm_out,
  output logic       period_start,
  output logic [7:0] active_duty,
  output logic       ramping,
  output logic [1:0] dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [7:0] PRESC_MAX = 8'(CLK_DIV - 1);
  localparam logic [7:0] STEP_MAX  = 8'd99;
  localparam logic [7:0] RAMP_INC  = 8'(RAMP_STEP);

  state_t      state;
  state_t      stateNext;
  logic [7:0]  targetReg;
  logic [7:0]  prescCnt;
  logic [7:0]  prescNext;
  logic [6:0]  stepCnt;
  logic [6:0]  stepNext;
  logic [7:0]  dutyNext;
  logic        startNext;
  logic        pwmNext;

  logic        tick;
  logic        boundary;
  logic [8:0]  rampSum;
  logic [7:0]  rampVal;
  logic [7:0]  boundaryDuty;
  logic [7:0]  entryDuty;
  logic [7:0]  dutyClamped;

  assign dutyClamped = (pwm_duty > 8'd100) ? 8'd100 : pwm_duty;

  // Step timing. A period boundary is the last prescaler cycle of step 99.
  assign tick     = (prescCnt == PRESC_MAX);
  assign boundary = tick && ({1'b0, stepCnt} == STEP_MAX);

  // Compute the ramp in 9 bits so that active_duty + RAMP_STEP cannot wrap before
  // it is clamped to the target.
  assign rampSum      = {1'b0, active_duty} + {1'b0, RAMP_INC};
  assign rampVal      = (rampSum > {1'b0, targetReg}) ? targetReg : rampSum[7:0];
  assign boundaryDuty = (targetReg > active_duty) ? rampVal : targetReg;
  assign entryDuty    = (RAMP_INC < targetReg) ? RAMP_INC : targetReg;

  // Next-state, counter and output logic. The outputs are computed from the
  // post-update values, so the registered pwm_out lines up with the counters.
  always_comb begin
    stateNext = state;
    prescNext = prescCnt;
    stepNext  = stepCnt;
    dutyNext  = active_duty;
    startNext = 1'b0;
    case (state)
      IDLE: begin
        prescNext = 8'd0;
        stepNext  = 7'd0;
        dutyNext  = 8'd0;
        if (enable) begin
          stateNext = RAMP;
          dutyNext  = entryDuty;
          startNext = 1'b1;
        end
      end
      RAMP, RUN: begin
        if (!enable) begin
          // Stopping has priority over a boundary update in the same cycle.
          stateNext = IDLE;
          prescNext = 8'd0;
          stepNext  = 7'd0;
          dutyNext  = 8'd0;
        end else begin
          prescNext = tick ? 8'd0 : prescCnt + 8'd1;
          if (tick) begin
            stepNext = ({1'b0, stepCnt} == STEP_MAX) ? 7'd0 : stepCnt + 7'd1;
          end
          if (boundary) begin
            dutyNext  = boundaryDuty;
            stateNext = (boundaryDuty == targetReg) ? RUN : RAMP;
            startNext = 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        prescNext = 8'd0;
        stepNext  = 7'd0;
        dutyNext  = 8'd0;
      end
    endcase
    pwmNext = (stateNext != IDLE) && ({1'b0, stepNext} < dutyNext);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      targetReg    <= 8'd0;
      prescCnt     <= 8'd0;
      stepCnt      <= 7'd0;
      active_duty  <= 8'd0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= stateNext;
      targetReg    <= dutyClamped;
      prescCnt     <= prescNext;
      stepCnt      <= stepNext;
      active_duty  <= dutyNext;
      pwm_out      <= pwmNext;
      period_start <= startNext;
    end
  end

  assign ramping  = (state == RAMP);
  assign dbgState = state;

endmodule

// File: tb/tb_pwm_generator.sv
// Testbench for pwm_generator. Two instances share the same inputs.
// Instance 0 is fast (CLK_DIV=1, RAMP_STEP=5). Instance 1 is slow (CLK_DIV=10, RAMP_STEP=40).
// The reference model tracks one position counter per period, 0..100*CLK_DIV-1.
// It also tracks the applied duty and updates that duty once per period.
module tb_pwm_generator;

  localparam int W = 13;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  pwm_duty;
  logic [1:0]  pwm_o;
  logic [1:0]  ps_o;
  logic [1:0]  rmp_o;
  logic [15:0] duty_o;
  logic [3:0]  dbg_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  int div_p[2] = '{1, 10};
  int rs_p[2]  = '{5, 40};

  bit m_run[2];
  bit m_ramp[2];
  bit m_start[2];
  bit m_pwm[2];
  int m_pos[2];
  int m_duty[2];
  int m_tgt[2];
  int obs_hi[2];
  int obs_len[2];

  pwm_generator #(.CLK_DIV(1), .RAMP_STEP(5)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_duty(pwm_duty),
    .pwm_out(pwm_o[0]), .period_start(ps_o[0]), .active_duty(duty_o[7:0]),
    .ramping(rmp_o[0]), .dbgState(dbg_o[1:0])
  );

  pwm_generator #(.CLK_DIV(10), .RAMP_STEP(40)) u_dut_slow (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_duty(pwm_duty),
    .pwm_out(pwm_o[1]), .period_start(ps_o[1]), .active_duty(duty_o[15:8]),
    .ramping(rmp_o[1]), .dbgState(dbg_o[3:2])
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model plus scoreboard. The model advances on each edge. After the
  // edge has settled, the DUT outputs are compared with the expected words.
  always @(posedge clk) begin
    bit           bnd[2];
    int           prev_duty[2];
    int           old_t;
    logic [W-1:0] e;
    logic [W-1:0] a;
    for (int i = 0; i < 2; i++) begin
      bnd[i]       = 1'b0;
      prev_duty[i] = m_duty[i];
      m_start[i]   = 1'b0;
      if (!rst_n) begin
        m_run[i] = 0; m_ramp[i] = 0; m_pos[i] = 0; m_duty[i] = 0; m_tgt[i] = 0;
      end else begin
        old_t    = m_tgt[i];
        m_tgt[i] = (pwm_duty > 100) ? 100 : int'(pwm_duty);
        if (!m_run[i]) begin
          if (enable) begin
            m_run[i] = 1; m_pos[i] = 0; m_ramp[i] = 1; m_start[i] = 1;
            m_duty[i] = min_i(rs_p[i], old_t);
          end
        end else if (!enable) begin
          m_run[i] = 0; m_ramp[i] = 0; m_pos[i] = 0; m_duty[i] = 0;
        end else if (m_pos[i] == 100 * div_p[i] - 1) begin
          bnd[i]     = 1'b1;
          m_pos[i]   = 0;
          m_duty[i]  = (old_t > m_duty[i]) ? min_i(m_duty[i] + rs_p[i], old_t) : old_t;
          m_ramp[i]  = (m_duty[i] != old_t);
          m_start[i] = 1;
        end else begin
          m_pos[i]++;
        end
      end
      m_pwm[i] = m_run[i] && (m_pos[i] < m_duty[i] * div_p[i]);
      exp_q.push_back({(!m_run[i]) ? 2'd0 : (m_ramp[i] ? 2'd1 : 2'd2),
                       m_pwm[i], m_start[i], m_ramp[i], 8'(m_duty[i])});
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      a = {dbg_o[2*i +: 2], pwm_o[i], ps_o[i], rmp_o[i], duty_o[8*i +: 8]};
      check_val($sformatf("pwm_out[%0d]", i), 32'(a[10]), 32'(e[10]));
      check_val($sformatf("period_start[%0d]", i), 32'(a[9]), 32'(e[9]));
      check_val($sformatf("ramping[%0d]", i), 32'(a[8]), 32'(e[8]));
      check_val($sformatf("active_duty[%0d]", i), 32'(a[7:0]), 32'(e[7:0]));
      check_val($sformatf("state[%0d]", i), 32'(a[12:11]), 32'(e[12:11]));
      // Measure high time and length of each completed period.
      if (bnd[i]) begin
        check_val($sformatf("high_time[%0d]", i), 32'(obs_hi[i]), 32'(prev_duty[i] * div_p[i]));
        check_val($sformatf("period_len[%0d]", i), 32'(obs_len[i]), 32'(100 * div_p[i]));
      end
      if (ps_o[i]) begin
        obs_hi[i] = 0; obs_len[i] = 0;
      end
      obs_len[i]++;
      if (pwm_o[i]) obs_hi[i]++;
    end
  end

  // Driver tasks
  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    run_cycles(n);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input bit en, input logic [7:0] d);
    enable   = en;
    pwm_duty = d;
  endtask

  // Wait until the fast instance is in the last cycle of a period. The wait is bounded.
  task automatic wait_fast_last();
    int k;
    k = 0;
    while (!(m_run[0] && m_pos[0] == 99) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val("align_timeout", 32'(k < 500), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; pwm_duty = 8'd0;
    @(negedge clk);
    do_reset(3);
    run_cycles(2);

    // Slow instance, duty 37: periods of 1000 cycles with 370 high cycles.
    set_in(1, 8'd37);
    run_cycles(3200);
    set_in(0, 8'd37);
    run_cycles(3);

    // Fast instance: ramp 5,10,15,20, then run at 20.
    pwm_duty = 8'd20; run_cycles(2);
    enable = 1'b1;
    run_cycles(700);

    // Run at 60, then drop to 30 in the middle of a period.
    pwm_duty = 8'd60; run_cycles(1500);
    wait_fast_last(); run_cycles(40);
    pwm_duty = 8'd30; run_cycles(300);

    // Clamp a target above 100, then drop to zero.
    pwm_duty = 8'd200; run_cycles(2500);
    pwm_duty = 8'd0; run_cycles(300);

    // Drop enable on a boundary cycle while the ramp is still running.
    pwm_duty = 8'd50; run_cycles(320);
    wait_fast_last();
    enable = 1'b0; run_cycles(20);

    // Apply a one-cycle reset in the middle of the ramp.
    set_in(1, 8'd80); run_cycles(250);
    do_reset(1);
    run_cycles(400);

    // Randomized segments.
    for (int s = 0; s < 30; s++) begin
      pwm_duty = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(101, 255))
                                             : 8'($urandom_range(0, 100));
      if ($urandom_range(0, 7) == 0) enable = ~enable;
      else enable = 1'b1;
      if ($urandom_range(0, 9) == 0) do_reset(1);
      run_cycles($urandom_range(1, 400));
    end
    run_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter CLK_DIV, default 10, SHALL set the number of clk cycles per PWM step (legal range 1..255).
REQ-002 Parameter RAMP_STEP, default 5, SHALL set the maximum increase of applied duty per PWM period (legal range 1..100).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 enable  input  1  SHALL be the run request: 1 = generate PWM, 0 = stop.
REQ-006 pwm_duty  input  8  SHALL be the target duty in percent (0..100), taken from the defuzzification stage.
REQ-007 pwm_out  output  1  SHALL be the PWM waveform.
REQ-008 period_start  output  1  SHALL be a one-cycle pulse marking the first clk of each PWM period.
REQ-009 active_duty  output  8  SHALL be the duty currently applied to pwm_out.
REQ-010 ramping  output  1  SHALL be 1 while the FSM is in RAMP.

Function
REQ-011 target_reg SHALL sample pwm_duty every clk; values >100 SHALL be clamped to 100.
REQ-012 The prescaler presc_cnt SHALL count 0..CLK_DIV-1 and wrap; tick = (presc_cnt == CLK_DIV-1).
REQ-013 The step counter step_cnt SHALL advance on tick, counting 0..99 and wrapping 99->0.
REQ-014 Period boundary SHALL be the cycle with tick and step_cnt == 99.
REQ-015 The FSM SHALL have exactly three states: IDLE, RAMP, RUN.
REQ-016 In IDLE, presc_cnt, step_cnt and active_duty SHALL be held at 0, and pwm_out, period_start and ramping SHALL be 0.
REQ-017 IDLE with enable=1 SHALL transition to RAMP at the next edge, with active_duty loaded to min(RAMP_STEP, target_reg) and counters at 0.
REQ-018 At each period boundary in RAMP or RUN, if target_reg > active_duty, active_duty SHALL become min(active_duty+RAMP_STEP, target_reg); otherwise active_duty SHALL become target_reg (decreases are immediate).
REQ-019 After a boundary update, the next state SHALL be RUN if the new active_duty equals target_reg, otherwise RAMP.
REQ-020 active_duty SHALL change only at period boundaries or on IDLE entry/exit; a mid-period pwm_duty change SHALL NOT alter the current period.
REQ-021 The sum active_duty+RAMP_STEP SHALL be computed 9 bits wide; no wrap-around.
REQ-022 pwm_out SHALL be a registered output equal to (state != IDLE) and (step_cnt < active_duty), evaluated on the post-update register values.
REQ-023 active_duty=0 SHALL give pwm_out constantly 0; active_duty=100 SHALL give pwm_out constantly 1 with no glitch at wrap.
REQ-024 period_start SHALL be 1 for exactly one clk on the first cycle of each period: the first cycle after IDLE->RAMP, and the first cycle with step_cnt=0 after a wrap.
REQ-025 enable=0 in RAMP or RUN SHALL force IDLE at the next edge, regardless of any simultaneous period boundary; pwm_out SHALL be 0 from that edge on.
REQ-026 Period length SHALL be 100*CLK_DIV clk cycles; high time SHALL be active_duty*CLK_DIV cycles.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, all counters 0, target_reg 0, active_duty 0, and pwm_out, period_start, ramping 0, overriding enable.
REQ-028 Reset asserted mid-period SHALL abort the period; after release with enable=1, operation SHALL restart per REQ-017.

Verification
REQ-029 CLK_DIV=1, RAMP_STEP=5, pwm_duty=20, enable rises -> active_duty 5,10,15,20 on successive periods; ramping falls with 20; then 20 high / 80 low cycles per 100.
REQ-030 In RUN at 60, pwm_duty drops to 30 mid-period -> current period keeps 60 high cycles; next period 30 high; stays in RUN.
REQ-031 pwm_duty=200 -> target clamps to 100; after ramp, pwm_out constant 1 across wraps; pwm_duty=0 -> pwm_out constant 0 from the next period.
REQ-032 CLK_DIV=10 -> period_start pulses every 1000 cycles, one cycle wide; duty 37 gives 370 high cycles.
REQ-033 enable falls on a period-boundary cycle -> IDLE next edge, pwm_out 0, active_duty 0, no boundary update applied.
REQ-034 rst_n low for one cycle mid-RAMP -> all outputs 0 next edge; after release, ramp restarts from min(RAMP_STEP, target) with period_start pulse.
